// File: rtl/alu_packet_engine.sv
// alu_packet_engine: parses byte-stream command packets (opcode, reserved, LEN lo/hi, payload)
// and either echoes the payload or reduces 32-bit little-endian operands into a 4-byte result.
// Ports: clk_i/rst_i (async active-high), in_* byte input (valid/ready), out_* byte output (valid/ready).
// Latency: echo byte valid 1 cycle after acceptance; first result byte 1 cycle after last payload byte.
// Backpressure: output register holds while stalled; echo input throttles on a full output register.
// Optional: define ALU_MUL_EN to enable opcode 0x88 (low 32 bits of product); otherwise 0x88 is drained.
module alu_packet_engine (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD  = 8'hAD;
`ifdef ALU_MUL_EN
  localparam logic [7:0] OPC_MUL  = 8'h88;
`endif

  typedef enum logic [2:0] {
    S_OPC, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND, S_DRAIN, S_RESULT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] opnd_q, opnd_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        first_q, first_d;
  logic [1:0]  res_idx_q, res_idx_d;
  logic        res_pend_q, res_pend_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  // Low for the first cycle after reset so in_ready_o reads 0 while reset is applied.
  logic        run_q;

  logic        in_fire;
  logic        out_slot_free;
  logic        opc_is_mul;
  logic        opc_is_alu;
  logic        enter_result;
  logic [15:0] len_full;
  logic [15:0] pay_len;
  logic [31:0] word;
  logic [31:0] combined;

  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx);
    return v[8*idx +: 8];
  endfunction

`ifdef ALU_MUL_EN
  assign opc_is_mul = (opc_q == OPC_MUL);
  assign combined   = opc_is_mul ? (acc_q * word) : (acc_q + word);
`else
  assign opc_is_mul = 1'b0;
  assign combined   = acc_q + word;
`endif

  assign opc_is_alu    = (opc_q == OPC_ADD) || opc_is_mul;
  assign out_slot_free = !out_valid_q || out_ready_i;
  assign len_full      = {in_data_i, len_lo_q};
  assign pay_len       = (len_full < 16'd4) ? 16'd0 : (len_full - 16'd4);
  assign word          = {in_data_i, opnd_q};

  always_comb begin
    in_ready_o = 1'b0;
    if (run_q) begin
      case (state_q)
        S_ECHO:   in_ready_o = out_slot_free;
        S_RESULT: in_ready_o = 1'b0;
        default:  in_ready_o = 1'b1;
      endcase
    end
  end

  assign in_fire     = in_valid_i && in_ready_o;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    len_lo_d     = len_lo_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    byte_idx_d   = byte_idx_q;
    first_d      = first_q;
    res_idx_d    = res_idx_q;
    res_pend_d   = res_pend_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q && !out_ready_i;
    enter_result = 1'b0;

    case (state_q)
      S_OPC: begin
        if (in_fire) begin
          opc_d   = in_data_i;
          state_d = S_RSV;
        end
      end
      S_RSV: begin
        if (in_fire) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (in_fire) begin
          len_lo_d = in_data_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (in_fire) begin
          rem_d      = pay_len;
          acc_d      = 32'd0;
          first_d    = 1'b1;
          byte_idx_d = 2'd0;
          if (pay_len != 16'd0) begin
            if (opc_q == OPC_ECHO)  state_d = S_ECHO;
            else if (opc_is_alu)    state_d = S_OPERAND;
            else                    state_d = S_DRAIN;
          end else if (opc_is_alu) begin
            enter_result = 1'b1;
          end else begin
            state_d = S_OPC;
          end
        end
      end
      S_ECHO: begin
        if (in_fire) begin
          out_data_d  = in_data_i;
          out_valid_d = 1'b1;
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_OPC;
        end
      end
      S_OPERAND: begin
        if (in_fire) begin
          rem_d = rem_q - 16'd1;
          // Trailing 1-3 bytes never reach byte 3, so they are absorbed without a combine.
          if (byte_idx_q == 2'd3) begin
            acc_d      = first_q ? word : combined;
            first_d    = 1'b0;
            byte_idx_d = 2'd0;
          end else begin
            opnd_d[8*byte_idx_q +: 8] = in_data_i;
            byte_idx_d                = byte_idx_q + 2'd1;
          end
          if (rem_q == 16'd1) enter_result = 1'b1;
        end
      end
      S_DRAIN: begin
        if (in_fire) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_OPC;
        end
      end
      S_RESULT: begin
        // res_pend_q: byte res_idx_q still waits for the output register (a trailing
        // echo byte of the previous packet may have been stalled there).
        if (res_pend_q) begin
          if (out_slot_free) begin
            out_data_d  = byte_of(acc_q, res_idx_q);
            out_valid_d = 1'b1;
            res_pend_d  = 1'b0;
          end
        end else if (out_valid_q && out_ready_i) begin
          if (res_idx_q == 2'd3) begin
            state_d = S_OPC;
          end else begin
            res_idx_d   = res_idx_q + 2'd1;
            out_data_d  = byte_of(acc_q, res_idx_q + 2'd1);
            out_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_OPC;
    endcase

    if (enter_result) begin
      state_d   = S_RESULT;
      res_idx_d = 2'd0;
      if (out_slot_free) begin
        out_data_d  = acc_d[7:0];
        out_valid_d = 1'b1;
        res_pend_d  = 1'b0;
      end else begin
        res_pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_OPC;
      opc_q       <= 8'h00;
      len_lo_q    <= 8'h00;
      rem_q       <= 16'd0;
      acc_q       <= 32'd0;
      opnd_q      <= 24'd0;
      byte_idx_q  <= 2'd0;
      first_q     <= 1'b1;
      res_idx_q   <= 2'd0;
      res_pend_q  <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      byte_idx_q  <= byte_idx_d;
      first_q     <= first_d;
      res_idx_q   <= res_idx_d;
      res_pend_q  <= res_pend_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// tb_alu_packet_engine: drives command packets into alu_packet_engine and checks the output
// byte stream, latencies and stall stability against a packet-level reference model.
// Build with or without ALU_MUL_EN; expectations for opcode 0x88 follow the macro.
module tb_alu_packet_engine;

  typedef logic [7:0] bq_t[$];

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   drv_to   = 0;
  int   stall_viol = 0;
  bit   rdy_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bq_t  got;
  int   got_cyc[$];
  int   acc_cyc[$];

  alu_packet_engine dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    #1;
    out_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Output monitor: sampled mid-cycle; a transfer happens at the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (prev_stall && (!out_valid_o || out_data_o !== prev_data)) stall_viol++;
      if (out_valid_o && out_ready_i) begin
        got.push_back(out_data_o);
        got_cyc.push_back(cyc);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference model: expected output bytes for one whole packet.
  function automatic bq_t model(input bq_t pkt);
    bq_t r;
    int len, p, n;
    logic [31:0] acc, w;
    r   = {};
    len = {pkt[3], pkt[2]};
    p   = (len < 4) ? 0 : len - 4;
    n   = p / 4;
    if (pkt[0] == 8'hEC) begin
      for (int i = 0; i < p; i++) r.push_back(pkt[4 + i]);
    end else if (pkt[0] == 8'hAD || (MUL_EN && pkt[0] == 8'h88)) begin
      acc = 32'd0;
      for (int k = 0; k < n; k++) begin
        w = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
        if (k == 0)               acc = w;
        else if (pkt[0] == 8'hAD) acc = acc + w;
        else                      acc = acc * w;
      end
      for (int b = 0; b < 4; b++) r.push_back(acc[8*b +: 8]);
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    in_data_i  = b;
    in_valid_i = 1'b1;
    while (!ok && t < 300) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ok = 1'b1;
        acc_cyc.push_back(cyc);
      end else begin
        @(posedge clk_i);
        #1;
        t++;
      end
    end
    if (ok) begin
      @(posedge clk_i);
      #1;
    end else begin
      drv_to++;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input bq_t pkt, input bit gaps);
    foreach (pkt[i]) begin
      send_byte(pkt[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 3000) begin
      @(posedge clk_i);
      t++;
    end
    repeat (10) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h want 00", out_data_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", in_ready_o); end
  endtask

  task automatic test_echo();
    bq_t pkt, exp;
    int g0, a0;
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    exp = '{8'h41, 8'h42, 8'h43};
    g0 = got.size(); a0 = acc_cyc.size();
    send_pkt(pkt, 1'b0);
    wait_out(g0 + 3);
    n_checks++; if (drv_to !== 0) begin n_fail++; $display("FAIL echo_accept: timeouts %0d want 0", drv_to); end
    n_checks++; if (got.size() - g0 !== 3) begin n_fail++; $display("FAIL echo_count: got %0d want 3", got.size() - g0); end
    for (int i = 0; i < 3 && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== exp[i]) begin n_fail++; $display("FAIL echo_byte%0d: got %h want %h", i, got[g0+i], exp[i]); end
      n_checks++; if (got_cyc[g0+i] !== acc_cyc[a0+4+i] + 1) begin n_fail++; $display("FAIL echo_lat%0d: out cyc %0d want %0d", i, got_cyc[g0+i], acc_cyc[a0+4+i] + 1); end
    end
  endtask

  task automatic test_add();
    bq_t pkt, exp;
    int g0, a0;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    exp = '{8'h01, 8'h00, 8'h00, 8'h00};
    g0 = got.size(); a0 = acc_cyc.size();
    send_pkt(pkt, 1'b0);
    wait_out(g0 + 4);
    n_checks++; if (got.size() - g0 !== 4) begin n_fail++; $display("FAIL add_count: got %0d want 4", got.size() - g0); end
    for (int i = 0; i < 4 && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== exp[i]) begin n_fail++; $display("FAIL add_byte%0d: got %h want %h", i, got[g0+i], exp[i]); end
      n_checks++; if (got_cyc[g0+i] !== acc_cyc[a0+11] + 1 + i) begin n_fail++; $display("FAIL add_lat%0d: cyc %0d want %0d", i, got_cyc[g0+i], acc_cyc[a0+11] + 1 + i); end
    end
  endtask

  task automatic test_mul();
    bq_t pkt, exp;
    int g0;
    pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
            8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    if (MUL_EN) exp = '{8'h00, 8'h00, 8'h0F, 8'h00};
    else        exp = {};
    exp.push_back(8'h5A);
    g0 = got.size();
    send_pkt(pkt, 1'b0);
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, 1'b0);
    wait_out(g0 + exp.size());
    n_checks++; if (got.size() - g0 !== exp.size()) begin n_fail++; $display("FAIL mul_count: got %0d want %0d", got.size() - g0, exp.size()); end
    for (int i = 0; i < exp.size() && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== exp[i]) begin n_fail++; $display("FAIL mul_byte%0d: got %h want %h", i, got[g0+i], exp[i]); end
    end
  endtask

  task automatic test_edge_cases();
    int g0, a0;
    // N=0 add: four zero bytes, first one the cycle after LEN_HI is accepted.
    g0 = got.size(); a0 = acc_cyc.size();
    send_pkt('{8'hAD, 8'h00, 8'h04, 8'h00}, 1'b0);
    wait_out(g0 + 4);
    n_checks++; if (got.size() - g0 !== 4) begin n_fail++; $display("FAIL add0_count: got %0d want 4", got.size() - g0); end
    for (int i = 0; i < 4 && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== 8'h00) begin n_fail++; $display("FAIL add0_byte%0d: got %h want 00", i, got[g0+i]); end
    end
    if (got.size() > g0) begin
      n_checks++; if (got_cyc[g0] !== acc_cyc[a0+3] + 1) begin n_fail++; $display("FAIL add0_lat: cyc %0d want %0d", got_cyc[g0], acc_cyc[a0+3] + 1); end
    end
    // Unknown opcode drains its payload silently; the following echo must parse.
    g0 = got.size();
    send_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22}, 1'b0);
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77}, 1'b0);
    wait_out(g0 + 1);
    n_checks++; if (got.size() - g0 !== 1) begin n_fail++; $display("FAIL unk_count: got %0d want 1", got.size() - g0); end
    if (got.size() > g0) begin
      n_checks++; if (got[g0] !== 8'h77) begin n_fail++; $display("FAIL unk_next: got %h want 77", got[g0]); end
    end
  endtask

  task automatic test_backpressure();
    bq_t pkt;
    int g0, v0;
    pkt = '{8'hEC, 8'h00, 8'd24, 8'h00};
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
    g0 = got.size(); v0 = stall_viol;
    rdy_rand = 1'b1;
    send_pkt(pkt, 1'b1);
    wait_out(g0 + 20);
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (got.size() - g0 !== 20) begin n_fail++; $display("FAIL bp_count: got %0d want 20", got.size() - g0); end
    for (int i = 0; i < 20 && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== pkt[4+i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, got[g0+i], pkt[4+i]); end
    end
    n_checks++; if (stall_viol - v0 !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_viol - v0); end
  endtask

  task automatic test_random();
    bq_t pkt, exp, e;
    int g0, v0, len, p, sel;
    logic [7:0] opc;
    exp = {};
    g0 = got.size(); v0 = stall_viol;
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 4);
      opc = (sel == 0) ? 8'hEC : (sel == 1) ? 8'hAD : (sel == 2) ? 8'h88 :
            (sel == 3) ? 8'h55 : 8'($urandom);
      len = $urandom_range(0, 26);
      p   = (len < 4) ? 0 : len - 4;
      pkt = '{opc, 8'($urandom), 8'(len), 8'(len >> 8)};
      for (int i = 0; i < p; i++) pkt.push_back(8'($urandom));
      e = model(pkt);
      foreach (e[i]) exp.push_back(e[i]);
      send_pkt(pkt, 1'b1);
    end
    wait_out(g0 + exp.size());
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if (got.size() - g0 !== exp.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", got.size() - g0, exp.size()); end
    for (int i = 0; i < exp.size() && g0 + i < got.size(); i++) begin
      n_checks++; if (got[g0+i] !== exp[i]) begin n_fail++; $display("FAIL rnd_byte%0d: got %h want %h", i, got[g0+i], exp[i]); end
    end
    n_checks++; if (stall_viol - v0 !== 0) begin n_fail++; $display("FAIL rnd_stable: %0d unstable stalls want 0", stall_viol - v0); end
    n_checks++; if (drv_to !== 0) begin n_fail++; $display("FAIL rnd_accept: timeouts %0d want 0", drv_to); end
  endtask

  task automatic test_mid_reset();
    int g0;
    send_pkt('{8'hAD, 8'h00}, 1'b0);
    rst_i = 1'b1;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL mrst_ready: got %b want 0", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", out_valid_o); end
    n_checks++; if (out_data_o !== 8'h00) begin n_fail++; $display("FAIL mrst_data: got %h want 00", out_data_o); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    g0 = got.size();
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99}, 1'b0);
    wait_out(g0 + 1);
    n_checks++; if (got.size() - g0 !== 1) begin n_fail++; $display("FAIL mrst_count: got %0d want 1", got.size() - g0); end
    if (got.size() > g0) begin
      n_checks++; if (got[g0] !== 8'h99) begin n_fail++; $display("FAIL mrst_echo: got %h want 99", got[g0]); end
    end
  endtask

  initial begin
    in_valid_i = 1'b0;
    in_data_i  = 8'h00;
    rst_i      = 1'b1;
    test_reset();
    test_echo();
    test_add();
    test_mul();
    test_edge_cases();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
